// File: rtl/clkdiv_multi.sv
// Multi-channel programmable tick generator with glitch-free divisor reload.
// Define CLKDIV_SQUARE_EN to add the per-channel 50% duty Sq outputs.
module clkdiv_multi #(
    parameter int          CHW         = 2,
    parameter int          BITS        = 27,
    parameter int unsigned DEFAULT_DIV = 100_000_000
) (
    input  logic                 Clkin,
    input  logic                 Rst,
    input  logic                 WrEn,
    input  logic [CHW-1:0]       WrCh,
    input  logic [BITS-1:0]      WrData,
    input  logic [2**CHW-1:0]    Run,
    input  logic                 Sync,
    output logic [2**CHW-1:0]    Tick,
`ifdef CLKDIV_SQUARE_EN
    output logic [2**CHW-1:0]    Sq,
`endif
    output logic                 WrAck
);

    localparam int              CH  = 2**CHW;
    localparam logic [BITS-1:0] DEF = BITS'(DEFAULT_DIV);

    logic wrack_q;

    always_ff @(posedge Clkin) begin
        if (Rst) begin
            wrack_q <= 1'b0;
        end else begin
            wrack_q <= WrEn;
        end
    end

    assign WrAck = wrack_q;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [BITS-1:0] div_q, div_d;
        logic [BITS-1:0] shd_q, shd_d;
        logic [BITS-1:0] cnt_q, cnt_d;
        logic [BITS-1:0] eff, nxt_shd;
        logic            pnd_q, pnd_d;
        logic            tick_q, tick_d;
        logic            hit, pend, wrap;

        assign hit     = WrEn && (WrCh == CHW'(g));
        assign nxt_shd = hit ? WrData : shd_q;
        assign pend    = hit | pnd_q;
        // Divisors 0 and 1 both collapse to a period of one cycle.
        assign eff     = (div_q == '0) ? BITS'(1) : div_q;
        assign wrap    = (cnt_q == eff - BITS'(1));

        always_comb begin
            div_d  = div_q;
            shd_d  = nxt_shd;
            cnt_d  = cnt_q;
            pnd_d  = pend;
            tick_d = 1'b0;
            if (Sync) begin
                cnt_d = '0;
                if (pend) begin
                    div_d = nxt_shd;
                    pnd_d = 1'b0;
                end
            end else if (Run[g]) begin
                if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (pend) begin
                        div_d = nxt_shd;
                        pnd_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + BITS'(1);
                end
            end else if (pend) begin
                div_d = nxt_shd;
                pnd_d = 1'b0;
                cnt_d = '0;
            end
        end

        always_ff @(posedge Clkin) begin
            if (Rst) begin
                div_q  <= DEF;
                shd_q  <= DEF;
                cnt_q  <= '0;
                pnd_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                shd_q  <= shd_d;
                cnt_q  <= cnt_d;
                pnd_q  <= pnd_d;
                tick_q <= tick_d;
            end
        end

        assign Tick[g] = tick_q;

`ifdef CLKDIV_SQUARE_EN
        logic sq_q, sq_d;

        always_comb begin
            sq_d = sq_q;
            if (Sync) begin
                sq_d = 1'b0;
            end else if (tick_d) begin
                sq_d = ~sq_q;
            end
        end

        always_ff @(posedge Clkin) begin
            if (Rst) begin
                sq_q <= 1'b0;
            end else begin
                sq_q <= sq_d;
            end
        end

        assign Sq[g] = sq_q;
`endif
    end

endmodule
